// File: rtl/onehot_decoder_stream_if.sv
// Handshake bundle for onehot_decoder_stream: code-in stream and one-hot-out stream.
// When DECODER_PARITY_EN is defined the bundle also carries d_par (producer side)
// and err (decoder side).
interface onehot_decoder_stream_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] d;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y;
`ifdef DECODER_PARITY_EN
    logic             d_par;
    logic             err;
`endif

`ifdef DECODER_PARITY_EN
    modport master (
        output in_valid, d, en, d_par, out_ready,
        input  in_ready, out_valid, y, err
    );
    modport slave (
        input  in_valid, d, en, d_par, out_ready,
        output in_ready, out_valid, y, err
    );
`else
    modport master (
        output in_valid, d, en, out_ready,
        input  in_ready, out_valid, y
    );
    modport slave (
        input  in_valid, d, en, out_ready,
        output in_ready, out_valid, y
    );
`endif
endinterface

// File: rtl/onehot_decoder_stream.sv
// Streaming binary-to-one-hot decoder with a 2-entry FIFO between the input and
// output handshakes, plus a saturating count of delivered words.
// Optional build macro DECODER_PARITY_EN: adds even-parity checking of d against
// d_par; bad words are consumed but dropped and flagged by a one-cycle err pulse.
module onehot_decoder_stream #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    onehot_decoder_stream_if.slave bus,
    output logic [CNT_W-1:0]     cnt
);
    localparam int OUT_W = 2 ** SEL_W;

    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             par_ok;
    logic             push;
    logic             pop;
    logic [OUT_W-1:0] word;

    // Readiness and validity come from the registered occupancy only, so there is
    // no combinational path from out_ready or in_valid to either handshake output.
    assign bus.in_ready  = rst_n & (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.y         = bus.out_valid ? mem[rd_ptr] : '0;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;

`ifdef DECODER_PARITY_EN
    assign par_ok = ((^bus.d) == bus.d_par);
`else
    assign par_ok = 1'b1;
`endif

    assign push = accept & par_ok;

    // Decode at enqueue time so the stored entry is already the output word.
    assign word = bus.en ? ({{(OUT_W-1){1'b0}}, 1'b1} << bus.d) : '0;

    // FIFO storage, pointers and occupancy; reset discards every buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Delivered-word counter, saturating at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef DECODER_PARITY_EN
    // One-cycle error pulse following the edge that consumed a bad-parity word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err <= 1'b0;
        end else begin
            bus.err <= accept & ~par_ok;
        end
    end
`endif

endmodule
